// File: rtl/komut_pkg.sv
// -----------------------------------------------------------------------------
// komut_pkg
// Shared types and constants for the instruction fetch/decode/issue sequencer.
//   durum_t       : sequencer state encoding
//   KOMUT_NOP     : instruction register value after reset (addi x0,x0,0)
//   PC_ADIM       : PC increment per instruction
//   *_W           : counter widths
//   helpers       : saturating increments and the per-state output pattern
// -----------------------------------------------------------------------------
package komut_pkg;

    typedef enum logic [2:0] {
        BOSTA  = 3'd0,
        GETIR  = 3'd1,
        COZ    = 3'd2,
        GONDER = 3'd3,
        DUR    = 3'd4
    } durum_t;

    localparam logic [31:0] KOMUT_NOP   = 32'h0000_0013;
    localparam logic [31:0] PC_ADIM     = 32'd4;
    localparam logic [31:0] ADRES_MASKE = 32'hFFFF_FFFC;

    localparam int KOMUT_SAYAC_W = 16;
    localparam int HATA_SAYAC_W  = 8;
    localparam int ZAMAN_SAYAC_W = 8;

    // Issued-instruction counter increment, holding at all-ones.
    function automatic logic [KOMUT_SAYAC_W-1:0] komut_arttir(
        input logic [KOMUT_SAYAC_W-1:0] deger
    );
        if (deger == {KOMUT_SAYAC_W{1'b1}}) begin
            return deger;
        end else begin
            return deger + {{(KOMUT_SAYAC_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Illegal-instruction counter increment, holding at all-ones.
    function automatic logic [HATA_SAYAC_W-1:0] hata_arttir(
        input logic [HATA_SAYAC_W-1:0] deger
    );
        if (deger == {HATA_SAYAC_W{1'b1}}) begin
            return deger;
        end else begin
            return deger + {{(HATA_SAYAC_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Output pattern {bellek_istek, cikis_gecerli, durdu} for a state being entered.
    function automatic logic [2:0] cikis_kodu(input durum_t durum);
        case (durum)
            GETIR:   return 3'b100;
            GONDER:  return 3'b010;
            DUR:     return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/komut_getir_kontrol_zaman_asimi_sayac.sv
// -----------------------------------------------------------------------------
// zaman_asimi_sayac
// Loadable down-counter that measures how long a fetch has been waiting.
//   clk, rst   : clock, synchronous active-high reset (counter -> 0)
//   yukle      : load `baslangic` (start of a new wait window)
//   azalt      : decrement by one, holding at zero
//   baslangic  : reload value (window length minus one)
//   bitti      : counter is zero, i.e. the current cycle is the last allowed one
// -----------------------------------------------------------------------------
module zaman_asimi_sayac
    import komut_pkg::*;
#(
    parameter int W = ZAMAN_SAYAC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         yukle,
    input  logic         azalt,
    input  logic [W-1:0] baslangic,
    output logic         bitti
);

    logic [W-1:0] sayac_r;

    // Down-counter: load has priority over decrement; stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sayac_r <= {W{1'b0}};
        end else if (yukle) begin
            sayac_r <= baslangic;
        end else if (azalt && (sayac_r != {W{1'b0}})) begin
            sayac_r <= sayac_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            sayac_r <= sayac_r;
        end
    end

    assign bitti = (sayac_r == {W{1'b0}});

endmodule

// File: rtl/komut_getir_kontrol.sv
// -----------------------------------------------------------------------------
// komut_getir_kontrol
// Multi-cycle fetch / decode / issue sequencer for the RV32 decode path.
// Owns the PC and the instruction register, fetches over a request/ack
// handshake, lets an external decoder judge `komut`, and issues legal
// instructions to execute over valid/ready.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   basla                    : start pulse (only honoured when idle)
//   bellek_istek/_adres      : fetch request and address (= pc)
//   bellek_hazir/_veri       : fetch acknowledge and returned word
//   komut / hata             : instruction register to decoder, illegal flag back
//   cikis_gecerli/_hazir     : issue handshake to execute stage
//   dallan / dallan_adres    : redirect strobe and target (word aligned here)
//   pc, durdu, zaman_asimi   : current PC, halted, halted-by-timeout (sticky)
//   komut_sayac, hata_sayac  : saturating issued / illegal counts
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module komut_getir_kontrol
    import komut_pkg::*;
#(
    parameter logic [31:0] BASLANGIC_ADRES = 32'h0000_0000,
    parameter int          ZAMAN_ASIMI     = 16,
    parameter bit          HATADA_DUR      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     basla,
    output logic                     bellek_istek,
    output logic [31:0]              bellek_adres,
    input  logic                     bellek_hazir,
    input  logic [31:0]              bellek_veri,
    output logic [31:0]              komut,
    input  logic                     hata,
    output logic                     cikis_gecerli,
    input  logic                     cikis_hazir,
    input  logic                     dallan,
    input  logic [31:0]              dallan_adres,
    output logic [31:0]              pc,
    output logic                     durdu,
    output logic                     zaman_asimi,
    output logic [KOMUT_SAYAC_W-1:0] komut_sayac,
    output logic [HATA_SAYAC_W-1:0]  hata_sayac
);

    // The counter reads zero in the last permitted wait cycle, so it is
    // loaded with the window length minus one.
    localparam logic [ZAMAN_SAYAC_W-1:0] ZA_YUKLE = ZAMAN_SAYAC_W'(ZAMAN_ASIMI - 1);

    durum_t                    durum_r;
    logic [31:0]               pc_r;
    logic [31:0]               komut_r;
    logic                      istek_r;
    logic                      gecerli_r;
    logic                      durdu_r;
    logic                      zaman_asimi_r;
    logic [KOMUT_SAYAC_W-1:0]  komut_sayac_r;
    logic [HATA_SAYAC_W-1:0]   hata_sayac_r;

    logic                      zs_yukle_s;
    logic                      zs_azalt_s;
    logic                      zs_bitti_s;
    logic [31:0]               hedef_s;
    logic [31:0]               pc_artik_s;

    assign hedef_s    = dallan_adres & ADRES_MASKE;
    assign pc_artik_s = pc_r + PC_ADIM;  // wraps silently at the top of memory

    // Timeout window control: reload on every entry into GETIR (start,
    // redirect, ack, skip, issue); count down only while waiting in GETIR.
    always_comb begin
        zs_yukle_s = 1'b0;
        zs_azalt_s = 1'b0;
        case (durum_r)
            BOSTA: begin
                zs_yukle_s = basla;
            end
            GETIR: begin
                if (dallan || bellek_hazir) begin
                    zs_yukle_s = 1'b1;
                end else begin
                    zs_azalt_s = 1'b1;
                end
            end
            COZ, GONDER: begin
                zs_yukle_s = 1'b1;
            end
            default: begin
                zs_yukle_s = 1'b0;
                zs_azalt_s = 1'b0;
            end
        endcase
    end

    zaman_asimi_sayac #(
        .W (ZAMAN_SAYAC_W)
    ) u_zaman_asimi_sayac (
        .clk       (clk),
        .rst       (rst),
        .yukle     (zs_yukle_s),
        .azalt     (zs_azalt_s),
        .baslangic (ZA_YUKLE),
        .bitti     (zs_bitti_s)
    );

    // Sequencer FSM with PC, instruction register, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            durum_r                         <= BOSTA;
            pc_r                            <= BASLANGIC_ADRES;
            komut_r                         <= KOMUT_NOP;
            {istek_r, gecerli_r, durdu_r}   <= 3'b000;
            zaman_asimi_r                   <= 1'b0;
            komut_sayac_r                   <= {KOMUT_SAYAC_W{1'b0}};
            hata_sayac_r                    <= {HATA_SAYAC_W{1'b0}};
        end else begin
            case (durum_r)
                BOSTA: begin
                    if (basla) begin
                        durum_r                       <= GETIR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GETIR);
                    end else begin
                        durum_r                       <= BOSTA;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(BOSTA);
                    end
                end

                GETIR: begin
                    if (dallan) begin
                        // Restart the fetch at the target; any ack data is dropped.
                        pc_r                          <= hedef_s;
                        durum_r                       <= GETIR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GETIR);
                    end else if (bellek_hazir) begin
                        komut_r                       <= bellek_veri;
                        durum_r                       <= COZ;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(COZ);
                    end else if (zs_bitti_s) begin
                        zaman_asimi_r                 <= 1'b1;
                        durum_r                       <= DUR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(DUR);
                    end else begin
                        durum_r                       <= GETIR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GETIR);
                    end
                end

                COZ: begin
                    // An illegal word is counted even when a redirect overrides the halt.
                    if (hata) begin
                        hata_sayac_r <= hata_arttir(hata_sayac_r);
                    end else begin
                        hata_sayac_r <= hata_sayac_r;
                    end

                    if (dallan) begin
                        pc_r                          <= hedef_s;
                        durum_r                       <= GETIR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GETIR);
                    end else if (hata && HATADA_DUR) begin
                        durum_r                       <= DUR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(DUR);
                    end else if (hata) begin
                        pc_r                          <= pc_artik_s;
                        durum_r                       <= GETIR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GETIR);
                    end else begin
                        durum_r                       <= GONDER;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GONDER);
                    end
                end

                GONDER: begin
                    // A handshake coinciding with a redirect still counts as issued.
                    if (gecerli_r && cikis_hazir) begin
                        komut_sayac_r <= komut_arttir(komut_sayac_r);
                    end else begin
                        komut_sayac_r <= komut_sayac_r;
                    end

                    if (dallan) begin
                        pc_r                          <= hedef_s;
                        durum_r                       <= GETIR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GETIR);
                    end else if (gecerli_r && cikis_hazir) begin
                        pc_r                          <= pc_artik_s;
                        durum_r                       <= GETIR;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GETIR);
                    end else begin
                        durum_r                       <= GONDER;
                        {istek_r, gecerli_r, durdu_r} <= cikis_kodu(GONDER);
                    end
                end

                DUR: begin
                    // Terminal until reset; start and redirect are ignored.
                    durum_r                       <= DUR;
                    {istek_r, gecerli_r, durdu_r} <= cikis_kodu(DUR);
                end

                default: begin
                    durum_r                       <= BOSTA;
                    {istek_r, gecerli_r, durdu_r} <= cikis_kodu(BOSTA);
                end
            endcase
        end
    end

    assign bellek_istek  = istek_r;
    assign bellek_adres  = pc_r;
    assign komut         = komut_r;
    assign cikis_gecerli = gecerli_r;
    assign pc            = pc_r;
    assign durdu         = durdu_r;
    assign zaman_asimi   = zaman_asimi_r;
    assign komut_sayac   = komut_sayac_r;
    assign hata_sayac    = hata_sayac_r;

endmodule

// File: tb/tb_komut_getir_kontrol.sv
// -----------------------------------------------------------------------------
// tb_komut_getir_kontrol
// Directed bench for komut_getir_kontrol. Instance A halts on illegal words,
// instance B (same stimulus) skips them. Fetched legal words are queued as
// expected issues and compared on each observed issue handshake of A.
// -----------------------------------------------------------------------------
module tb_komut_getir_kontrol;

    logic        clk = 1'b0;
    logic        rst;
    logic        basla;
    logic        bellek_hazir;
    logic [31:0] bellek_veri;
    logic        cikis_hazir;
    logic        dallan;
    logic [31:0] dallan_adres;

    logic        a_istek, a_gecerli, a_durdu, a_za, a_hata;
    logic [31:0] a_adres, a_komut, a_pc;
    logic [15:0] a_ks;
    logic [7:0]  a_hs;

    logic        b_istek, b_gecerli, b_durdu, b_za, b_hata;
    logic [31:0] b_adres, b_komut, b_pc;
    logic [15:0] b_ks;
    logic [7:0]  b_hs;

    int          kontrol_sayisi = 0;
    int          hata_sayisi    = 0;
    int          dongu          = 0;
    logic [31:0] beklenen_q[$];
    logic [31:0] bek;

    always #5 clk = ~clk;

    always @(posedge clk) dongu <= dongu + 1;

    // Bench decoder model: any word whose low two bits are not 2'b11 is illegal.
    assign a_hata = (a_komut[1:0] != 2'b11);
    assign b_hata = (b_komut[1:0] != 2'b11);

    komut_getir_kontrol #(
        .BASLANGIC_ADRES (32'h0000_0000),
        .ZAMAN_ASIMI     (16),
        .HATADA_DUR      (1'b1)
    ) dut_a (
        .clk (clk), .rst (rst), .basla (basla),
        .bellek_istek (a_istek), .bellek_adres (a_adres),
        .bellek_hazir (bellek_hazir), .bellek_veri (bellek_veri),
        .komut (a_komut), .hata (a_hata),
        .cikis_gecerli (a_gecerli), .cikis_hazir (cikis_hazir),
        .dallan (dallan), .dallan_adres (dallan_adres),
        .pc (a_pc), .durdu (a_durdu), .zaman_asimi (a_za),
        .komut_sayac (a_ks), .hata_sayac (a_hs)
    );

    komut_getir_kontrol #(
        .BASLANGIC_ADRES (32'h0000_0000),
        .ZAMAN_ASIMI     (16),
        .HATADA_DUR      (1'b0)
    ) dut_b (
        .clk (clk), .rst (rst), .basla (basla),
        .bellek_istek (b_istek), .bellek_adres (b_adres),
        .bellek_hazir (bellek_hazir), .bellek_veri (bellek_veri),
        .komut (b_komut), .hata (b_hata),
        .cikis_gecerli (b_gecerli), .cikis_hazir (cikis_hazir),
        .dallan (dallan), .dallan_adres (dallan_adres),
        .pc (b_pc), .durdu (b_durdu), .zaman_asimi (b_za),
        .komut_sayac (b_ks), .hata_sayac (b_hs)
    );

    // Issue monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && a_gecerli === 1'b1 && cikis_hazir === 1'b1) begin
            bek = (beklenen_q.size() > 0) ? beklenen_q.pop_front() : 32'hxxxx_xxxx;
            kontrol_sayisi++;
            assert (a_komut === bek) else begin
                hata_sayisi++;
                $error("FAIL issued_komut: observed=%h expected=%h", a_komut, bek);
            end
        end
    end

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        kontrol_sayisi++;
        assert (gozlenen === beklenen) else begin
            hata_sayisi++;
            $error("FAIL %s: observed=%h expected=%h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic tik;
        @(posedge clk);
        #1;
    endtask

    task automatic sifirla;
        rst          = 1'b1;
        basla        = 1'b0;
        bellek_hazir = 1'b0;
        dallan       = 1'b0;
        tik();
        tik();
        rst = 1'b0;
    endtask

    task automatic baslat;
        basla = 1'b1;
        tik();
        basla = 1'b0;
    endtask

    // Wait for a request, check its address, ack in request cycle `gecikme`.
    task automatic getir(input int gecikme, input logic [31:0] veri,
                         input logic [31:0] adres, input logic yasal);
        int n = 0;
        while (a_istek !== 1'b1 && n < 20) begin
            tik();
            n++;
        end
        kontrol("istek_var", 32'(a_istek), 32'd1);
        kontrol("istek_adres", a_adres, adres);
        repeat (gecikme - 1) tik();
        bellek_hazir = 1'b1;
        bellek_veri  = veri;
        if (yasal) beklenen_q.push_back(veri);
        tik();
        bellek_hazir = 1'b0;
        bellek_veri  = $urandom;
    endtask

    // Wait until an issue handshake is presented, then step past it.
    task automatic gonder_bekle;
        int n = 0;
        while (!(a_gecerli === 1'b1 && cikis_hazir === 1'b1) && n < 20) begin
            tik();
            n++;
        end
        kontrol("gonder_zaman", 32'(n < 20), 32'd1);
        tik();
    endtask

    initial begin
        int onceki;
        int n;
        bellek_veri  = 32'd0;
        cikis_hazir  = 1'b1;
        dallan_adres = 32'd0;

        // Reset state (checked while reset is still asserted)
        rst = 1'b1; basla = 1'b0; bellek_hazir = 1'b0; dallan = 1'b0;
        tik();
        tik();
        kontrol("rst_istek",   32'(a_istek),   32'd0);
        kontrol("rst_gecerli", 32'(a_gecerli), 32'd0);
        kontrol("rst_durdu",   32'(a_durdu),   32'd0);
        kontrol("rst_za",      32'(a_za),      32'd0);
        kontrol("rst_komut",   a_komut,        32'h0000_0013);
        kontrol("rst_pc",      a_pc,           32'h0000_0000);
        kontrol("rst_ks",      32'(a_ks),      32'd0);
        kontrol("rst_hs",      32'(a_hs),      32'd0);
        rst = 1'b0;

        // 1: single legal fetch with ack in the second request cycle
        tik();
        kontrol("bosta_istek", 32'(a_istek), 32'd0);
        baslat();
        getir(2, 32'h00A0_0093, 32'h0000_0000, 1'b1);
        gonder_bekle();
        kontrol("t1_pc", a_pc, 32'h0000_0004);
        kontrol("t1_ks", 32'(a_ks), 32'd1);

        // 2: back-to-back legal words, one issue every three cycles
        sifirla();
        baslat();
        onceki = 0;
        for (int i = 0; i < 3; i++) begin
            getir(1, 32'h0010_0093 + 32'(i << 20), 32'(i * 4), 1'b1);
            gonder_bekle();
            if (i > 0) kontrol("t2_aralik", 32'(dongu - onceki), 32'd3);
            onceki = dongu;
        end
        kontrol("t2_pc", a_pc, 32'h0000_000C);
        kontrol("t2_ks", 32'(a_ks), 32'd3);

        // 3: illegal word; A halts, B skips to the next word
        sifirla();
        baslat();
        getir(1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        tik();
        kontrol("t3_durdu",  32'(a_durdu), 32'd1);
        kontrol("t3_hs",     32'(a_hs),    32'd1);
        kontrol("t3_istek",  32'(a_istek), 32'd0);
        kontrol("t3_b_pc",   b_pc,         32'h0000_0004);
        kontrol("t3_b_istek",32'(b_istek), 32'd1);
        kontrol("t3_b_hs",   32'(b_hs),    32'd1);
        baslat();
        tik();
        kontrol("t3_basla_yok_durdu", 32'(a_durdu), 32'd1);
        kontrol("t3_basla_yok_istek", 32'(a_istek), 32'd0);
        kontrol("t3_ks", 32'(a_ks), 32'd0);

        // 4: no ack -> halt after exactly 16 request cycles
        sifirla();
        baslat();
        n = 0;
        while (a_istek === 1'b1 && n < 40) begin
            n++;
            tik();
        end
        kontrol("t4_istek_dongu", 32'(n),     32'd16);
        kontrol("t4_za",          32'(a_za),  32'd1);
        kontrol("t4_durdu",       32'(a_durdu), 32'd1);
        kontrol("t4_istek",       32'(a_istek), 32'd0);

        // 5: execute stalls, then redirect in the handshake cycle
        sifirla();
        cikis_hazir = 1'b0;
        baslat();
        getir(1, 32'h0050_0113, 32'h0000_0000, 1'b1);
        tik();
        for (int i = 0; i < 5; i++) begin
            kontrol("t5_gecerli", 32'(a_gecerli), 32'd1);
            kontrol("t5_komut",   a_komut,        32'h0050_0113);
            tik();
        end
        kontrol("t5_ks_bekle", 32'(a_ks), 32'd0);
        cikis_hazir  = 1'b1;
        dallan       = 1'b1;
        dallan_adres = 32'h0000_0103;
        tik();
        dallan      = 1'b0;
        cikis_hazir = 1'b0;
        kontrol("t5_ks",    32'(a_ks),      32'd1);
        kontrol("t5_pc",    a_pc,           32'h0000_0100);
        kontrol("t5_adres", a_adres,        32'h0000_0100);
        kontrol("t5_istek", 32'(a_istek),   32'd1);
        kontrol("t5_gecerli_dus", 32'(a_gecerli), 32'd0);

        // 6: reset mid-fetch with ack high wins over the ack
        bellek_hazir = 1'b1;
        bellek_veri  = 32'h0030_0193;
        rst          = 1'b1;
        tik();
        bellek_hazir = 1'b0;
        rst          = 1'b0;
        kontrol("t6_istek", 32'(a_istek), 32'd0);
        kontrol("t6_komut", a_komut,      32'h0000_0013);
        kontrol("t6_pc",    a_pc,         32'h0000_0000);
        kontrol("t6_ks",    32'(a_ks),    32'd0);
        kontrol("t6_hs",    32'(a_hs),    32'd0);
        kontrol("t6_za",    32'(a_za),    32'd0);
        tik();
        kontrol("t6_bosta", 32'(a_istek), 32'd0);
        kontrol("kuyruk_bos", 32'(beklenen_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule
